xnor_gate: RTL and testbench

XNOR_GATE -- requirements
Module: xnor_gate

---
 rtl/xnor_gate_pkg.sv | 12 +
 rtl/xnor_popcount.sv | 20 ++
 rtl/xnor_gate.sv | 80 ++++++++
 tb/tb_xnor_gate.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/xnor_gate_pkg.sv
// Shared defaults and helpers for the xnor_gate block.
// Popcount width derives from the vector width.
package xnor_gate_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;

  function automatic int pop_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/xnor_popcount.sv
// Combinational ones counter over a W-bit vector.
// Result range is 0..W, so PW must be at least clog2(W+1).
module xnor_popcount
  import xnor_gate_pkg::*;
#(
  parameter int W  = DEF_WIDTH,
  parameter int PW = pop_w(W)
) (
  input  logic [W-1:0]  vec,
  output logic [PW-1:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) begin
      cnt = cnt + PW'(vec[i]);
    end
  end

endmodule

// File: rtl/xnor_gate.sv
// Scalar XNOR plus a registered vector equality compare
// with per-bit result, popcount and saturating match counter.
module xnor_gate
  import xnor_gate_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int PW    = pop_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  output logic             y,
  output logic             y_q,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             clr_cnt,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_eq,
  output logic             out_match,
  output logic [PW-1:0]    out_popcnt,
  output logic [CNT_W-1:0] match_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] eq;
  logic             match;
  logic [PW-1:0]    pop;

  assign y     = ~(a ^ b);
  assign eq    = ~(in_a ^ in_b);
  assign match = &eq;

  xnor_popcount #(
    .W  (WIDTH),
    .PW (PW)
  ) u_pop (
    .vec (eq),
    .cnt (pop)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= 1'b0;
    end else begin
      y_q <= y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_eq     <= '0;
      out_match  <= 1'b0;
      out_popcnt <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_eq     <= eq;
        out_match  <= match;
        out_popcnt <= pop;
      end
    end
  end

  // Clear wins over a same-cycle increment; counter sticks at max.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt <= '0;
    end else if (clr_cnt) begin
      match_cnt <= '0;
    end else if (in_valid && match && match_cnt != CNT_MAX) begin
      match_cnt <= match_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_xnor_gate.sv
// Directed self-checking bench for xnor_gate.
// Second instance uses CNT_W=2 to reach counter saturation.
module tb_xnor_gate;

  logic       clk;
  logic       rst_n;
  logic       a, b;
  logic       y, y_q;
  logic       in_valid;
  logic [7:0] in_a, in_b;
  logic       clr_cnt;
  logic       out_valid;
  logic [7:0] out_eq;
  logic       out_match;
  logic [3:0] out_popcnt;
  logic [15:0] match_cnt;

  logic       in_valid2, clr_cnt2;
  logic       y2, y_q2, out_valid2, out_match2;
  logic [7:0] out_eq2;
  logic [3:0] out_popcnt2;
  logic [1:0] match_cnt2;

  int total = 0;
  int bad   = 0;

  xnor_gate #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .y(y), .y_q(y_q),
    .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .clr_cnt(clr_cnt), .out_valid(out_valid), .out_eq(out_eq),
    .out_match(out_match), .out_popcnt(out_popcnt),
    .match_cnt(match_cnt)
  );

  xnor_gate #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .y(y2), .y_q(y_q2),
    .in_valid(in_valid2), .in_a(in_a), .in_b(in_b),
    .clr_cnt(clr_cnt2), .out_valid(out_valid2), .out_eq(out_eq2),
    .out_match(out_match2), .out_popcnt(out_popcnt2),
    .match_cnt(match_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic [7:0] eq;
    logic       m;
    logic [3:0] pc;
  } vec_t;

  typedef struct {
    logic a;
    logic b;
    logic y;
  } sc_t;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] va, input logic [7:0] vb,
                       input logic v, input logic c,
                       input logic v2, input logic c2);
    @(negedge clk);
    in_a = va; in_b = vb;
    in_valid = v; clr_cnt = c;
    in_valid2 = v2; clr_cnt2 = c2;
    @(posedge clk);
    #1;
  endtask

  vec_t vt[8];
  sc_t  st[4];
  logic [15:0] mcnt;

  initial begin
    st[0] = '{1'b0, 1'b0, 1'b1};
    st[1] = '{1'b1, 1'b0, 1'b0};
    st[2] = '{1'b0, 1'b1, 1'b0};
    st[3] = '{1'b1, 1'b1, 1'b1};

    vt[0] = '{8'hA5, 8'hA5, 8'hFF, 1'b1, 4'd8};
    vt[1] = '{8'hF0, 8'h0F, 8'h00, 1'b0, 4'd0};
    vt[2] = '{8'hF0, 8'hF1, 8'hFE, 1'b0, 4'd7};
    vt[3] = '{8'h00, 8'h00, 8'hFF, 1'b1, 4'd8};
    vt[4] = '{8'hFF, 8'h00, 8'h00, 1'b0, 4'd0};
    vt[5] = '{8'h12, 8'h34, 8'hD9, 1'b0, 4'd5};
    vt[6] = '{8'h80, 8'h00, 8'h7F, 1'b0, 4'd7};
    vt[7] = '{8'h3C, 8'h3C, 8'hFF, 1'b1, 4'd8};

    rst_n = 1'b0;
    a = 1'b0; b = 1'b1;
    in_valid = 1'b0; clr_cnt = 1'b0;
    in_valid2 = 1'b0; clr_cnt2 = 1'b0;
    in_a = 8'h00; in_b = 8'h00;
    #2;
    chk("rst_y_q", 64'(y_q), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_eq", 64'(out_eq), 64'd0);
    chk("rst_out_match", 64'(out_match), 64'd0);
    chk("rst_out_popcnt", 64'(out_popcnt), 64'd0);
    chk("rst_match_cnt", 64'(match_cnt), 64'd0);
    chk("rst_y_comb", 64'(y), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Scalar truth table, y_q one edge later
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = st[i].a; b = st[i].b;
      #1;
      chk($sformatf("y[%0d]", i), 64'(y), 64'(st[i].y));
      @(posedge clk);
      #1;
      chk($sformatf("y_q[%0d]", i), 64'(y_q), 64'(st[i].y));
    end

    // Back-to-back vector stream
    mcnt = 16'd0;
    for (int i = 0; i < 8; i++) begin
      drive(vt[i].va, vt[i].vb, 1'b1, 1'b0, 1'b0, 1'b0);
      if (vt[i].m) mcnt = mcnt + 16'd1;
      chk($sformatf("valid[%0d]", i), 64'(out_valid), 64'd1);
      chk($sformatf("eq[%0d]", i), 64'(out_eq), 64'(vt[i].eq));
      chk($sformatf("match[%0d]", i), 64'(out_match), 64'(vt[i].m));
      chk($sformatf("pop[%0d]", i), 64'(out_popcnt), 64'(vt[i].pc));
      chk($sformatf("mcnt[%0d]", i), 64'(match_cnt), 64'(mcnt));
    end

    // Idle cycle: outputs hold, valid drops
    drive(8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle_valid", 64'(out_valid), 64'd0);
    chk("idle_eq_hold", 64'(out_eq), 64'hFF);
    chk("idle_pop_hold", 64'(out_popcnt), 64'd8);
    chk("idle_cnt_hold", 64'(match_cnt), 64'd3);

    // Clear beats simultaneous matching increment
    drive(8'h55, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("clr_prio", 64'(match_cnt), 64'd0);
    chk("clr_valid", 64'(out_valid), 64'd1);

    // Saturation on the 2-bit counter
    for (int i = 0; i < 5; i++) begin
      drive(8'hC3, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0);
      chk($sformatf("sat[%0d]", i), 64'(match_cnt2),
          64'((i < 3) ? i + 1 : 3));
    end
    drive(8'hC3, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("sat_clr", 64'(match_cnt2), 64'd0);

    // Async reset while a result is showing
    drive(8'h0F, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    chk("pre_rst_cnt", 64'(match_cnt), 64'd1);
    a = 1'b1; b = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_eq", 64'(out_eq), 64'd0);
    chk("mid_rst_match", 64'(out_match), 64'd0);
    chk("mid_rst_pop", 64'(out_popcnt), 64'd0);
    chk("mid_rst_cnt", 64'(match_cnt), 64'd0);
    chk("mid_rst_yq", 64'(y_q), 64'd0);
    chk("mid_rst_y11", 64'(y), 64'd1);
    a = 1'b0;
    #1;
    chk("mid_rst_y01", 64'(y), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_valid", 64'(out_valid), 64'd0);
    chk("post_rst_cnt", 64'(match_cnt), 64'd0);
    drive(8'hAA, 8'hAB, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("post_rst_eq", 64'(out_eq), 64'hFE);
    chk("post_rst_pop", 64'(out_popcnt), 64'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
